sr_icache_ctrl: RTL
===================

// Module: sr_icache_ctrl
// PURPOSE
//   Direct-mapped instruction-cache controller between the sr_cpu fetch port and backing instruction memory.
//   Looks up tag/valid on each fetch, refills a full line word-by-word on miss, then returns the word with im_drdy.
//   Sequences the tag/data arrays and the memory read port; the CPU stalls while im_drdy is low.
// PARAMETERS
//   ADDR_W      32  byte-address width; fetch addresses are word aligned (bits [1:0] ignored)
//   LINE_WORDS  4   32-bit words per line, power of two >= 2
//   LINES       16  number of lines, power of two >= 2
// PORTS
//   clk         in   1       system clock
//   rst_n       in   1       asynchronous active-low reset
//   im_req      in   1       fetch request; held high with im_addr stable until im_drdy
//   im_addr     in   ADDR_W  fetch byte address
//   im_rdata    out  32      fetched instruction, valid when im_drdy=1
//   im_drdy     out  1       one-cycle pulse: fetch complete
//   icache_inv  in   1       one-cycle pulse: invalidate all lines (fence.i)
//   mem_req     out  1       memory read request; held with mem_addr stable until mem_rvalid
//   mem_addr    out  ADDR_W  memory word byte address
//   mem_rvalid  in   1       memory read data valid (completes current mem_req)
//   mem_rdata   in   32      memory read data
//   hit_cnt     out  32      [SR_ICACHE_PERF_EN only] hit count
//   miss_cnt    out  32      [SR_ICACHE_PERF_EN only] miss count
// BEHAVIOUR
//   Address split: OFF_W=log2(LINE_WORDS), IDX_W=log2(LINES); word offset=addr[OFF_W+1:2],
//     index=addr[IDX_W+OFF_W+1:OFF_W+2], tag=addr[ADDR_W-1:IDX_W+OFF_W+2].
//   Reset: state=IDLE, all valid bits 0, im_drdy=0, im_rdata=0, mem_req=0, mem_addr=0, inv_pend=0, counters=0.
//   FSM states IDLE, LOOKUP, REFILL, RESP; arrays are synchronous-read.
//   IDLE: im_req=1 -> issue array read at index, go LOOKUP.
//   LOOKUP: valid && tag match -> hit: register word into im_rdata, go RESP.
//     miss -> word counter=0, mem_addr={tag,index,0..0}, mem_req=1, go REFILL.
//   REFILL: on mem_rvalid write mem_rdata to data[index][cnt]; capture into im_rdata if cnt==requested offset;
//     cnt!=LINE_WORDS-1 -> cnt+1, mem_addr+=4, mem_req stays 1;
//     last word -> mem_req=0, tag written, valid set, go RESP.
//   RESP: im_drdy=1 for exactly one cycle, im_rdata valid; next state IDLE (im_req in RESP ignored).
//   Latency: hit -> im_drdy 2 cycles after im_req first sampled; miss -> 2 + total memory wait cycles + LINE_WORDS.
//   Refill is always line-aligned from word 0, in ascending order; one outstanding memory request.
//   mem_rvalid outside REFILL ignored. im_addr change while im_req pending is illegal (bench assertion).
//   icache_inv: in IDLE clears all valid bits next edge; in any other state sets inv_pend, applied on the IDLE entry
//     after RESP (the just-refilled line is also invalidated). icache_inv and im_req same cycle in IDLE: invalidate wins,
//     request serviced next cycle (misses).
//   rst_n low mid-refill: immediate async return to reset values; partial line never valid.
// CONFIGURATION
//   SR_ICACHE_PERF_EN defined: hit_cnt/miss_cnt ports exist; +1 per LOOKUP hit/miss, wrap at 2^32, cleared by reset only.
//   Not defined: ports and counters absent; cache behaviour identical.
// STRUCTURE
//   Header sr_icache.vh: state encodings (`SR_IC_IDLE..`SR_IC_RESP), default LINE_WORDS/LINES, width-derivation macros.
//   Sub-module sr_icache_ram: LINES x (valid, tag, LINE_WORDS x 32) sync-read array, word write enable, global valid clear.
//   sr_icache_ctrl holds FSM, word counter, inv_pend, address split, perf counters.
// TESTING (LINE_WORDS=4, LINES=16, memory = addr^32'hA5A50000 unless stated)
//   Cold fetch 0x00 -> mem_addr 0x00,0x04,0x08,0x0C in order; im_drdy with im_rdata=0xA5A50000; miss_cnt=1.
//   Then fetch 0x08 -> no mem_req, im_drdy 2 cycles after im_req, im_rdata=0xA5A50008; hit_cnt=1.
//   Fetch 0x0C cold (line 0x100 range: fetch 0x10C) -> refill starts at 0x100, returns word 3 = 0xA5A5010C.
//   Fetch 0x100 then 0x00 (same index 0) -> both miss; 0x00 refill re-reads 0x00..0x0C.
//   Random 0-5 cycle memory waits, icache_inv pulsed mid-refill -> fetch completes correctly; next fetch same line misses.
//   rst_n low during 3rd refill word -> mem_req/im_drdy 0 immediately; after release fetch same address misses.

Source files
------------

// File: rtl/sr_icache_ctrl_pkg.sv
// Shared types and default geometry for the sr_icache_ctrl instruction cache.
// Optional feature macro used by the top: SR_ICACHE_PERF_EN (hit/miss counters).
package sr_icache_ctrl_pkg;

    // Default geometry: byte address width, words per line, number of lines
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LINES      = 16;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REFILL = 2'd2,
        ST_RESP   = 2'd3
    } ic_state_e;

    // Tag width left over after word offset, line index and byte offset
    function automatic int tag_width(input int addr_w, input int line_words, input int lines);
        return addr_w - $clog2(lines) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/sr_icache_ctrl_ram.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Synchronous read of a whole line (valid, tag, all words); per-word write,
// tag commit that also sets the line valid, and a global valid clear.
module sr_icache_ctrl_ram #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = $clog2(LINES),
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_en,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic                        rd_valid,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [LINE_WORDS-1:0][31:0] rd_line,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [OFF_W-1:0]            wr_off,
    input  logic [31:0]                 wr_data,
    input  logic                        tag_we,
    input  logic [TAG_W-1:0]            tag_wdata,
    input  logic                        clr_all
);

    logic [LINES-1:0]                valid_q;
    logic [TAG_W-1:0]                tag_q  [LINES];
    logic [LINE_WORDS-1:0][31:0]     data_q [LINES];

    // Valid bits: cleared by reset or invalidate, set when a refill commits its tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx][wr_off] <= wr_data;
        end
        if (tag_we) begin
            tag_q[wr_idx] <= tag_wdata;
        end
    end

    // Registered read port: one-cycle lookup latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_tag   <= '0;
            rd_line  <= '0;
        end else if (rd_en) begin
            rd_valid <= valid_q[rd_idx];
            rd_tag   <= tag_q[rd_idx];
            rd_line  <= data_q[rd_idx];
        end
    end

endmodule

// File: rtl/sr_icache_ctrl.sv
// Direct-mapped instruction-cache controller between the CPU fetch port and
// instruction memory. Hit: array read in IDLE, compare in LOOKUP, word out in RESP.
// Miss: full line refilled word 0..LINE_WORDS-1 with one outstanding request.
// Handshakes: im_req is held with im_addr stable until the one-cycle im_drdy pulse;
// mem_req is held with mem_addr stable until a cycle with mem_rvalid=1 completes it.
// Optional feature: define SR_ICACHE_PERF_EN to add hit_cnt/miss_cnt ports.
module sr_icache_ctrl
    import sr_icache_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LINES      = DEF_LINES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              im_req,
    input  logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_rdata,
    output logic              im_drdy,
    input  logic              icache_inv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef SR_ICACHE_PERF_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = tag_width(ADDR_W, LINE_WORDS, LINES);

    ic_state_e                   state;
    logic [ADDR_W-3:0]           req_addr;   // latched word address of the pending fetch
    logic [OFF_W-1:0]            cnt;        // refill word counter
    logic                        inv_pend;   // invalidate seen while busy

    logic [OFF_W-1:0]            req_off;
    logic [IDX_W-1:0]            req_idx;
    logic [TAG_W-1:0]            req_tag;
    logic                        rd_en;
    logic                        rd_valid;
    logic [TAG_W-1:0]            rd_tag;
    logic [LINE_WORDS-1:0][31:0] rd_line;
    logic                        hit;
    logic                        wr_en;
    logic                        last_word;
    logic                        tag_we;
    logic                        clr_all;

    // Byte-offset bits of the fetch address carry no information
    wire unused_byte_bits = &{1'b0, im_addr[1:0]};

    assign req_off   = req_addr[OFF_W-1:0];
    assign req_idx   = req_addr[IDX_W+OFF_W-1:OFF_W];
    assign req_tag   = req_addr[ADDR_W-3:IDX_W+OFF_W];
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign last_word = (cnt == OFF_W'(LINE_WORDS - 1));

    // Array read is skipped when an invalidate arrives with the request; the request is retried
    assign rd_en   = (state == ST_IDLE) && im_req && !icache_inv;
    assign wr_en   = (state == ST_REFILL) && mem_rvalid;
    assign tag_we  = wr_en && last_word;
    // Clear in IDLE immediately, otherwise on the way out of RESP so the fetch in flight completes
    assign clr_all = ((state == ST_IDLE) && icache_inv) ||
                     ((state == ST_RESP) && (inv_pend || icache_inv));

    sr_icache_ctrl_ram #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_idx    (im_addr[IDX_W+OFF_W+1:OFF_W+2]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_idx    (req_idx),
        .wr_off    (cnt),
        .wr_data   (mem_rdata),
        .tag_we    (tag_we),
        .tag_wdata (req_tag),
        .clr_all   (clr_all)
    );

    // Control FSM with registered CPU- and memory-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            im_drdy  <= 1'b0;
            im_rdata <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            inv_pend <= 1'b0;
            cnt      <= '0;
            req_addr <= '0;
        end else begin
            im_drdy <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rd_en) begin
                        req_addr <= im_addr[ADDR_W-1:2];
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (icache_inv) inv_pend <= 1'b1;
                    if (hit) begin
                        im_rdata <= rd_line[req_off];
                        im_drdy  <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        cnt      <= '0;
                        mem_addr <= {req_addr[ADDR_W-3:OFF_W], {(OFF_W+2){1'b0}}};
                        mem_req  <= 1'b1;
                        state    <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (icache_inv) inv_pend <= 1'b1;
                    if (mem_rvalid) begin
                        if (cnt == req_off) im_rdata <= mem_rdata;
                        if (last_word) begin
                            mem_req <= 1'b0;
                            im_drdy <= 1'b1;
                            state   <= ST_RESP;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(4);
                        end
                    end
                end
                ST_RESP: begin
                    inv_pend <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SR_ICACHE_PERF_EN
    // Hit/miss counters, one count per lookup, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
